// File: rtl/inst_encoder.sv
// RV32I instruction encoder: registers a field-level request, packs it into a
// 32-bit word with range/alignment/opcode checks, and emits it with an address.
module inst_encoder #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Instruction,
  output logic [31:0] out_addr,
  output logic        err_range,
  output logic        err_align,
  output logic        err_opcode,
  output logic [15:0] enc_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ENC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  logic [1:0]  state;
  logic [6:0]  op_q;
  logic [2:0]  f3_q;
  logic [6:0]  f7_q;
  logic [4:0]  rd_q;
  logic [4:0]  rs1_q;
  logic [4:0]  rs2_q;
  logic [31:0] imm_q;

  logic [31:0] enc_word;
  logic        range_bad;
  logic        align_bad;
  logic        op_bad;
  logic        xfer;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign xfer      = out_valid && out_ready;

  // A sign-extended field fits when its upper bits are all zeros or all ones.
  function automatic logic all_same(input logic [20:0] bits, input int unsigned width);
    logic [20:0] mask;
    mask = (21'h1 << width) - 21'h1;
    return ((bits & mask) == mask) || ((bits & mask) == 21'h0);
  endfunction

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    enc_word  = 32'h0;
    range_bad = 1'b0;
    align_bad = 1'b0;
    op_bad    = 1'b0;
    case (op_q)
      OP_R: enc_word = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
      OP_IMM, OP_LOAD, OP_JALR: begin
        enc_word  = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
        range_bad = !all_same(imm_q[31:11], 21);
      end
      OP_STORE: begin
        enc_word  = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
        range_bad = !all_same(imm_q[31:11], 21);
      end
      OP_BR: begin
        enc_word  = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                     imm_q[4:1], imm_q[11], op_q};
        range_bad = !all_same({1'b0, imm_q[31:12]}, 20);
        align_bad = imm_q[0];
      end
      OP_LUI, OP_AUIPC: begin
        enc_word  = {imm_q[31:12], rd_q, op_q};
        range_bad = (imm_q[11:0] != 12'h0);
      end
      OP_JAL: begin
        enc_word  = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, op_q};
        range_bad = !all_same({9'h0, imm_q[31:20]}, 12);
        align_bad = imm_q[0];
      end
      default: op_bad = 1'b1;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (in_valid) state <= ENC;
        ENC:     state <= OUT;
        OUT:     if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the request field registers are plain flops, reset alongside the rest
  // so no X ever reaches the encoder after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= 7'h0;
      f3_q  <= 3'h0;
      f7_q  <= 7'h0;
      rd_q  <= 5'h0;
      rs1_q <= 5'h0;
      rs2_q <= 5'h0;
      imm_q <= 32'h0;
    end else if (in_ready && in_valid) begin
      op_q  <= opcode;
      f3_q  <= funct3;
      f7_q  <= funct7;
      rd_q  <= rd;
      rs1_q <= rs1;
      rs2_q <= rs2;
      imm_q <= imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Instruction <= 32'h0;
      err_range   <= 1'b0;
      err_align   <= 1'b0;
      err_opcode  <= 1'b0;
    end else if (state == ENC) begin
      Instruction <= (range_bad || align_bad || op_bad) ? NOP_WORD : enc_word;
      err_range   <= err_range  | range_bad;
      err_align   <= err_align  | align_bad;
      err_opcode  <= err_opcode | op_bad;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_addr  <= ADDR_BASE;
      enc_count <= 16'h0;
    end else if (xfer) begin
      out_addr <= out_addr + 32'd4;
      if (enc_count != 16'hFFFF) enc_count <= enc_count + 16'd1;
    end
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 The block SHALL have parameter ADDR_BASE, default 32'h0000_0000, meaning the out_addr value after reset.
REQ-002 The block SHALL have parameter NOP_WORD, default 32'h0000_0013, meaning the word emitted for any rejected request.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge clk.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1, request present.
REQ-006 The block SHALL have port in_ready, output, 1, block can accept a request.
REQ-007 The block SHALL have ports opcode/funct3/funct7, input, 7/3/7, instruction fields.
REQ-008 The block SHALL have ports rd/rs1/rs2, input, 5 each, register indices.
REQ-009 The block SHALL have port imm, input, 32, signed byte offset, or the U-type value with the low 12 bits zero.
REQ-010 The block SHALL have ports out_valid (output, 1) and out_ready (input, 1), the output handshake.
REQ-011 The block SHALL have port Instruction, output, 32, the encoded RV32I word.
REQ-012 The block SHALL have port out_addr, output, 32, the word address paired with Instruction.
REQ-013 The block SHALL have ports err_range, err_align and err_opcode, output, 1 each, sticky error flags.
REQ-014 The block SHALL have port enc_count, output, 16, the number of completed output transfers.

Function
REQ-015 FSM states SHALL be IDLE, ENC and OUT.
- in_ready=1 only in IDLE.
- IDLE->ENC on in_valid&&in_ready; all input fields registered on that edge.
- ENC->OUT unconditionally; Instruction registered on the ENC edge.
- OUT->IDLE on out_ready.
REQ-016 Latency SHALL be: out_valid high exactly 2 cycles after the accept edge; max throughput one request per 3 cycles.
REQ-017 out_valid SHALL equal 1 only in OUT.
- Instruction and out_addr SHALL stay stable while out_valid=1 and out_ready=0.
- out_ready is ignored outside OUT.
REQ-018 Encoding SHALL be selected by opcode:
- R (0110011): {funct7,rs2,rs1,funct3,rd,op}; imm ignored, no range check.
- I/load/jalr (0010011/0000011/1100111): {imm[11:0],rs1,funct3,rd,op}.
- S (0100011): {imm[11:5],rs2,rs1,funct3,imm[4:0],op}.
- B (1100011): {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],op}.
- U lui/auipc (0110111/0010111): {imm[31:12],rd,op}.
- J jal (1101111): {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-019 Range checks SHALL be:
- I/S: imm[31:11] all equal.
- B: imm[31:12] all equal.
- J: imm[31:20] all equal.
- U: imm[11:0]==0.
- Any violation sets err_range.
REQ-020 Alignment check SHALL be: for B/J, imm[0]==1 sets err_align; err_align and err_range may be set by the same request.
REQ-021 Unknown opcode SHALL set err_opcode.
REQ-022 Any error on a request SHALL replace Instruction with NOP_WORD; the transfer still completes and counts.
REQ-023 Error flags SHALL be sticky, cleared only by reset, and set on the ENC edge.
REQ-024 out_addr SHALL increment by 4 on each out_valid&&out_ready edge, wrapping modulo 2^32.
REQ-025 enc_count SHALL increment on each out_valid&&out_ready edge and saturate at 16'hFFFF.
REQ-026 in_valid SHALL be ignored outside IDLE; the upstream holds the request until in_ready.

Reset
REQ-027 On rst_n low, asynchronously and regardless of state:
- FSM=IDLE; out_valid=0; Instruction=0; out_addr=ADDR_BASE; enc_count=0; all err flags=0.
- in_ready=1 once rst_n is high.
REQ-028 Reset asserted in ENC or OUT SHALL abort the pending word with no transfer and no count increment.

Verification
REQ-029 addi x1,x0,5 (op 0010011, rd=1, rs1=0, f3=0, imm=5), out_ready=1 -> Instruction=0x00500093 at accept+2, out_addr=0, enc_count=1 after the transfer.
REQ-030 beq x1,x2,-4 (imm=0xFFFFFFFC) then lui x5 imm=0x12345000 -> 0xFE208EE3 at out_addr 0, then 0x123452B7 at out_addr 4; no err flags.
REQ-031 addi with imm=4096 -> Instruction=0x00000013, err_range=1, which stays 1 after a following valid addi.
REQ-032 jal with imm=3 -> NOP_WORD and err_align=1; opcode 7'b1111111 -> NOP_WORD and err_opcode=1.
REQ-033 out_ready low for 5 cycles in OUT -> Instruction/out_addr stable, in_ready=0, in_valid ignored; transfer on the first out_ready=1 edge.
REQ-034 rst_n pulsed low in OUT -> out_valid=0 immediately, enc_count and out_addr at reset values, next accepted request emitted at ADDR_BASE.
